// File: rtl/chat_text_buffer.sv
// Text state behind the chat screen: the editable keyboard line, the outgoing and
// incoming scrolling histories, and the one-deep handoff of committed lines to the transmitter.
module chat_text_buffer #(
   parameter int NCHAR  = 16,
   parameter int NLINES = 5
) (
   input  logic                      clock_65mhz,
   input  logic                      reset,
   input  logic [7:0]                char_in,
   input  logic                      char_valid,
   input  logic [NCHAR*8-1:0]        rx_line,
   input  logic                      rx_valid,
   input  logic                      send_ready,
   output logic                      send_valid,
   output logic [NCHAR*8-1:0]        send_line,
   output logic [NCHAR*8-1:0]        keyboard,
   output logic [4:0]                kb_count,
   output logic [NCHAR*8*NLINES-1:0] messageout,
   output logic [NCHAR*8*NLINES-1:0] messagein
);

   localparam int LW = NCHAR * 8;
   localparam int HW = LW * NLINES;
   localparam logic [LW-1:0] BLANK = {NCHAR{8'h20}};
   localparam logic [4:0]    FULL  = 5'(NCHAR);

   typedef enum logic {
      IDLE,
      PEND
   } send_state_e;

   send_state_e   state_q;
   logic          send_valid_q;
   logic [LW-1:0] send_line_q;
   logic [LW-1:0] kb_q, kb_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [HW-1:0] mout_q;
   logic [HW-1:0] min_q;

   logic is_print;
   logic do_type;
   logic do_bksp;
   logic do_commit;

   assign is_print  = (char_in >= 8'h20) && (char_in <= 8'h7E);
   assign do_type   = char_valid && is_print && (cnt_q < FULL);
   assign do_bksp   = char_valid && (char_in == 8'h08) && (cnt_q != 5'd0);
   // Enter is gated by the pre-edge send state, so Enter beside send_ready in PEND is lost.
   assign do_commit = char_valid && (char_in == 8'h0D) && (cnt_q != 5'd0) && (state_q == IDLE);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      kb_d  = kb_q;
      cnt_d = cnt_q;
      if (do_commit) begin
         kb_d  = BLANK;
         cnt_d = 5'd0;
      end else if (do_type) begin
         for (int i = 0; i < NCHAR; i++) begin
            if (cnt_q == 5'(i)) kb_d[LW-1-8*i -: 8] = char_in;
         end
         cnt_d = cnt_q + 5'd1;
      end else if (do_bksp) begin
         for (int i = 0; i < NCHAR; i++) begin
            if (cnt_q == 5'(i + 1)) kb_d[LW-1-8*i -: 8] = 8'h20;
         end
         cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clock_65mhz) begin
      if (reset) begin
         // NOTE: the text stores are plain flops read directly by the display, so they are
         // reset to spaces rather than left undefined like a RAM would be.
         kb_q         <= BLANK;
         cnt_q        <= 5'd0;
         mout_q       <= {NLINES{BLANK}};
         min_q        <= {NLINES{BLANK}};
         send_line_q  <= BLANK;
         send_valid_q <= 1'b0;
         state_q      <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         kb_q  <= kb_d;
         cnt_q <= cnt_d;
         // Newest line enters at the top bits; line 0 falls off the bottom.
         if (do_commit) mout_q <= {kb_q, mout_q[HW-1:LW]};
         if (rx_valid)  min_q  <= {rx_line, min_q[HW-1:LW]};
         case (state_q)
            IDLE: begin
               if (do_commit) begin
                  state_q      <= PEND;
                  send_valid_q <= 1'b1;
                  send_line_q  <= kb_q;
               end
            end
            PEND: begin
               if (send_ready) begin
                  state_q      <= IDLE;
                  send_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign send_valid = send_valid_q;
   assign send_line  = send_line_q;
   assign keyboard   = kb_q;
   assign kb_count   = cnt_q;
   assign messageout = mout_q;
   assign messagein  = min_q;

endmodule

// File: tb/tb_chat_text_buffer.sv
// Bench for chat_text_buffer: a keystroke vector table, directed corner sequences,
// then random traffic compared against a string/queue model of the text state.
`timescale 1ns/1ps
module tb_chat_text_buffer;

   localparam int NCHAR  = 16;
   localparam int NLINES = 5;
   localparam int LW     = NCHAR * 8;
   localparam int HW     = LW * NLINES;
   localparam logic [LW-1:0] SP = {NCHAR{8'h20}};

   logic              clock_65mhz = 1'b0;
   logic              reset       = 1'b1;
   logic [7:0]        char_in     = 8'h00;
   logic              char_valid  = 1'b0;
   logic [LW-1:0]     rx_line     = '0;
   logic              rx_valid    = 1'b0;
   logic              send_ready  = 1'b0;
   logic              send_valid;
   logic [LW-1:0]     send_line;
   logic [LW-1:0]     keyboard;
   logic [4:0]        kb_count;
   logic [HW-1:0]     messageout;
   logic [HW-1:0]     messagein;

   always #5 clock_65mhz = ~clock_65mhz;

   chat_text_buffer #(.NCHAR(NCHAR), .NLINES(NLINES)) dut (
      .clock_65mhz(clock_65mhz),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .rx_line    (rx_line),
      .rx_valid   (rx_valid),
      .send_ready (send_ready),
      .send_valid (send_valid),
      .send_line  (send_line),
      .keyboard   (keyboard),
      .kb_count   (kb_count),
      .messageout (messageout),
      .messagein  (messagein)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Character 0 of the string lands in the top byte; short strings are space padded.
   function automatic logic [LW-1:0] str2line(input string s);
      logic [LW-1:0] v;
      logic [7:0]    b;
      v = '0;
      for (int i = 0; i < NCHAR; i++) begin
         b = (i < s.len()) ? s[i] : 8'h20;
         v = {v[LW-9:0], b};
      end
      return v;
   endfunction

   // Reference model: the input line as a string, histories as oldest-first queues.
   string         m_kb;
   logic [LW-1:0] m_out[$];
   logic [LW-1:0] m_in[$];
   bit            m_pend;
   logic [LW-1:0] m_send;

   task automatic model_reset();
      m_kb = "";
      m_out.delete();
      m_in.delete();
      for (int k = 0; k < NLINES; k++) begin
         m_out.push_back(SP);
         m_in.push_back(SP);
      end
      m_pend = 1'b0;
      m_send = SP;
   endtask

   task automatic model_step(input bit cv, input logic [7:0] c, input bit rv,
                             input logic [LW-1:0] rl, input bit sr);
      bit was_pend;
      bit commit;
      was_pend = m_pend;
      commit   = 1'b0;
      if (cv) begin
         if (c >= 8'h20 && c <= 8'h7E) begin
            if (m_kb.len() < NCHAR) m_kb = $sformatf("%s%c", m_kb, c);
         end else if (c == 8'h08) begin
            if (m_kb.len() > 0) m_kb = m_kb.substr(0, m_kb.len() - 2);
         end else if (c == 8'h0D) begin
            commit = (m_kb.len() > 0) && !was_pend;
         end
      end
      if (was_pend && sr) m_pend = 1'b0;
      if (commit) begin
         m_out.push_back(str2line(m_kb));
         void'(m_out.pop_front());
         m_send = str2line(m_kb);
         m_pend = 1'b1;
         m_kb   = "";
      end
      if (rv) begin
         m_in.push_back(rl);
         void'(m_in.pop_front());
      end
   endtask

   function automatic logic [HW-1:0] out_vec();
      logic [HW-1:0] v;
      v = '0;
      for (int k = NLINES - 1; k >= 0; k--) v = {v[HW-LW-1:0], m_out[k]};
      return v;
   endfunction

   function automatic logic [HW-1:0] in_vec();
      logic [HW-1:0] v;
      v = '0;
      for (int k = NLINES - 1; k >= 0; k--) v = {v[HW-LW-1:0], m_in[k]};
      return v;
   endfunction

   // Drive on the falling edge, let the rising edge sample, observe 1 ns later.
   task automatic apply(input bit cv, input logic [7:0] c, input bit rv,
                        input logic [LW-1:0] rl, input bit sr);
      @(negedge clock_65mhz);
      char_valid = cv;
      char_in    = c;
      rx_valid   = rv;
      rx_line    = rl;
      send_ready = sr;
      @(posedge clock_65mhz);
      #1;
      char_valid = 1'b0;
      rx_valid   = 1'b0;
      send_ready = 1'b0;
      model_step(cv, c, rv, rl, sr);
   endtask

   task automatic do_reset();
      @(negedge clock_65mhz);
      reset      = 1'b1;
      char_valid = 1'b0;
      rx_valid   = 1'b0;
      send_ready = 1'b0;
      @(posedge clock_65mhz);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " keyboard"},   keyboard,   SP);
      check({tag, " kb_count"},   kb_count,   0);
      check({tag, " send_valid"}, send_valid, 0);
      check({tag, " send_line"},  send_line,  SP);
      check({tag, " messageout"}, messageout, {NLINES{SP}});
      check({tag, " messagein"},  messagein,  {NLINES{SP}});
   endtask

   task automatic compare_all(input int cyc);
      string t;
      t = $sformatf("rand%0d", cyc);
      check({t, " keyboard"},   keyboard,   str2line(m_kb));
      check({t, " kb_count"},   kb_count,   m_kb.len());
      check({t, " send_valid"}, send_valid, m_pend);
      check({t, " send_line"},  send_line,  m_send);
      check({t, " messageout"}, messageout, out_vec());
      check({t, " messagein"},  messagein,  in_vec());
   endtask

   typedef struct packed {
      logic          cv;
      logic [7:0]    c;
      logic          sr;
      logic [4:0]    cnt;
      logic          sv;
      logic [LW-1:0] kb;
   } vec_t;

   localparam int NVEC = 23;
   vec_t tbl[NVEC];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 8'h48, 1'b0, 5'd1, 1'b0, str2line("H")};
      tbl[1]  = '{1'b1, 8'h49, 1'b0, 5'd2, 1'b0, str2line("HI")};
      tbl[2]  = '{1'b1, 8'h08, 1'b0, 5'd1, 1'b0, str2line("H")};
      tbl[3]  = '{1'b1, 8'h41, 1'b0, 5'd2, 1'b0, str2line("HA")};
      tbl[4]  = '{1'b1, 8'h08, 1'b0, 5'd1, 1'b0, str2line("H")};
      tbl[5]  = '{1'b1, 8'h08, 1'b0, 5'd0, 1'b0, SP};
      tbl[6]  = '{1'b1, 8'h08, 1'b0, 5'd0, 1'b0, SP};
      tbl[7]  = '{1'b1, 8'h0D, 1'b0, 5'd0, 1'b0, SP};
      tbl[8]  = '{1'b1, 8'h07, 1'b0, 5'd0, 1'b0, SP};
      tbl[9]  = '{1'b1, 8'h58, 1'b0, 5'd1, 1'b0, str2line("X")};
      tbl[10] = '{1'b1, 8'h0D, 1'b0, 5'd0, 1'b1, SP};
      tbl[11] = '{1'b1, 8'h59, 1'b0, 5'd1, 1'b1, str2line("Y")};
      tbl[12] = '{1'b1, 8'h0D, 1'b0, 5'd1, 1'b1, str2line("Y")};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, str2line("Y")};
      tbl[14] = '{1'b1, 8'h0D, 1'b0, 5'd0, 1'b1, SP};
      tbl[15] = '{1'b1, 8'h57, 1'b0, 5'd1, 1'b1, str2line("W")};
      tbl[16] = '{1'b1, 8'h0D, 1'b1, 5'd1, 1'b0, str2line("W")};
      tbl[17] = '{1'b1, 8'h0D, 1'b0, 5'd0, 1'b1, SP};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, SP};
      tbl[19] = '{1'b1, 8'h7F, 1'b0, 5'd0, 1'b0, SP};
      tbl[20] = '{1'b1, 8'h7E, 1'b0, 5'd1, 1'b0, str2line("~")};
      tbl[21] = '{1'b1, 8'h1F, 1'b0, 5'd1, 1'b0, str2line("~")};
      tbl[22] = '{1'b1, 8'h08, 1'b0, 5'd0, 1'b0, SP};

      model_reset();
      do_reset();
      repeat (2) apply(1'b0, 8'h00, 1'b0, '0, 1'b0);
      check_reset_state("reset");

      for (int i = 0; i < NVEC; i++) begin
         apply(tbl[i].cv, tbl[i].c, 1'b0, '0, tbl[i].sr);
         check($sformatf("vec%0d keyboard", i),   keyboard,   tbl[i].kb);
         check($sformatf("vec%0d kb_count", i),   kb_count,   tbl[i].cnt);
         check($sformatf("vec%0d send_valid", i), send_valid, tbl[i].sv);
      end
      check("table messageout", messageout,
            {str2line("W"), str2line("Y"), str2line("X"), SP, SP});
      check("table send_line", send_line, str2line("W"));

      // Overfill: the seventeenth key is dropped.
      do_reset();
      for (int i = 0; i < 17; i++) apply(1'b1, 8'h61 + 8'(i), 1'b0, '0, 1'b0);
      check("full keyboard", keyboard, str2line("abcdefghijklmnop"));
      check("full kb_count", kb_count, 16);

      // Six receptions into a five-line history: the first one scrolls away.
      for (int i = 0; i < 6; i++)
         apply(1'b0, 8'h00, 1'b1, str2line($sformatf("L%0d", i)), 1'b0);
      check("rx scroll messagein", messagein,
            {str2line("L5"), str2line("L4"), str2line("L3"), str2line("L2"), str2line("L1")});
      check("rx scroll keyboard kept", keyboard, str2line("abcdefghijklmnop"));

      // Enter, reception and send_ready all in one IDLE cycle.
      do_reset();
      apply(1'b1, 8'h5A, 1'b0, '0, 1'b0);
      apply(1'b1, 8'h0D, 1'b1, str2line("R"), 1'b1);
      check("same-cycle messageout", messageout, {str2line("Z"), SP, SP, SP, SP});
      check("same-cycle messagein",  messagein,  {str2line("R"), SP, SP, SP, SP});
      check("same-cycle send_valid", send_valid, 1);
      check("same-cycle send_line",  send_line,  str2line("Z"));
      check("same-cycle keyboard",   keyboard,   SP);
      check("same-cycle kb_count",   kb_count,   0);
      apply(1'b1, 8'h51, 1'b0, '0, 1'b0);
      do_reset();
      check_reset_state("mid-pend reset");

      for (int cyc = 0; cyc < 400; cyc++) begin
         bit            cv, rv, sr;
         logic [7:0]    c;
         logic [LW-1:0] rl;
         int            sel;
         cv  = ($urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 9);
         case (sel)
            6:       c = 8'h08;
            7:       c = 8'h0D;
            8:       c = 8'($urandom);
            9:       c = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h1F;
            default: c = 8'($urandom_range(32, 126));
         endcase
         rv = ($urandom_range(0, 4) == 0);
         rl = {$urandom, $urandom, $urandom, $urandom};
         sr = ($urandom_range(0, 9) < 3);
         apply(cv, c, rv, rl, sr);
         compare_all(cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
